// File: rtl/c2h_stream_arbiter.sv
// Packet-granular round-robin arbiter of NUM_SRC AXIS sources onto one C2H stream; 1-cycle arbitration, 1 idle cycle between packets.
// Granted source sees m_tready on its s_tready; all others are held off (s_tready=0) until their own grant.
module c2h_stream_arbiter #(
  parameter int NUM_SRC    = 2,
  parameter int DATA_WIDTH = 256,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                              TX_clk,
  input  logic                              TX_rst_n,
  input  logic                              link_up,
  input  logic [NUM_SRC-1:0]                s_tvalid,
  output logic [NUM_SRC-1:0]                s_tready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]     s_tdata,
  input  logic [NUM_SRC*(DATA_WIDTH/8)-1:0] s_tkeep,
  input  logic [NUM_SRC-1:0]                s_tlast,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic [DATA_WIDTH-1:0]             m_tdata,
  output logic [DATA_WIDTH/8-1:0]           m_tkeep,
  output logic                              m_tlast,
  output logic                              busy,
  output logic [1:0]                        grant_id,
  output logic [NUM_SRC*CNT_WIDTH-1:0]      pkt_cnt
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int SEL_W  = $clog2(NUM_SRC);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     grant_sel, last_sel;
  logic [SEL_W-1:0]     rr_pick;
  logic                 rr_hit;
  logic                 eop;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_SRC];

  // Scan starts one past the last completed source, so that source ranks lowest.
  always_comb begin
    int idx;
    idx     = 0;
    rr_pick = '0;
    rr_hit  = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(last_sel) + k) % NUM_SRC;
      if (!rr_hit && s_tvalid[idx]) begin
        rr_hit  = 1'b1;
        rr_pick = SEL_W'(idx);
      end
    end
  end

  assign eop = (state_q == BUSY) && m_tvalid && m_tready && m_tlast;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (link_up && rr_hit) state_d = BUSY;
      BUSY:    if (eop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge TX_clk or negedge TX_rst_n) begin
    if (!TX_rst_n) begin
      state_q   <= IDLE;
      grant_sel <= '0;
      last_sel  <= SEL_W'(NUM_SRC - 1);
      for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && link_up && rr_hit) grant_sel <= rr_pick;
      if (eop) begin
        last_sel         <= grant_sel;
        cnt_q[grant_sel] <= cnt_q[grant_sel] + CNT_WIDTH'(1);
      end
    end
  end

  // Outside BUSY every output is forced to its quiescent value.
  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (state_q == BUSY) begin
      m_tvalid            = s_tvalid[grant_sel];
      m_tdata             = s_tdata[int'(grant_sel)*DATA_WIDTH +: DATA_WIDTH];
      m_tkeep             = s_tkeep[int'(grant_sel)*KEEP_W +: KEEP_W];
      m_tlast             = s_tlast[grant_sel];
      s_tready[grant_sel] = m_tready;
    end
  end

  assign busy     = (state_q == BUSY);
  assign grant_id = 2'(grant_sel);

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt
    assign pkt_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end

endmodule

// File: tb/tb_c2h_stream_arbiter.sv
// Bench for c2h_stream_arbiter: directed scenarios plus a randomized phase against a queue-based reference model.
module tb_c2h_stream_arbiter;

  localparam int NS = 2;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int CW = 4;
  localparam int BW = DW + KW + 1;

  logic              TX_clk = 1'b0;
  logic              TX_rst_n;
  logic              link_up;
  logic [NS-1:0]     s_tvalid;
  logic [NS-1:0]     s_tready;
  logic [NS*DW-1:0]  s_tdata;
  logic [NS*KW-1:0]  s_tkeep;
  logic [NS-1:0]     s_tlast;
  logic              m_tvalid;
  logic              m_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tlast;
  logic              busy;
  logic [1:0]        grant_id;
  logic [NS*CW-1:0]  pkt_cnt;

  c2h_stream_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .TX_clk(TX_clk), .TX_rst_n(TX_rst_n), .link_up(link_up),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .busy(busy), .grant_id(grant_id), .pkt_cnt(pkt_cnt)
  );

  always #5 TX_clk = ~TX_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: per-source beat queues {last, keep, data}, ownership of the output port, completion log.
  logic [BW-1:0] q [NS][$];
  bit            pres [NS];
  bit            mb;
  int            mg;
  int            ml;
  int            mc [NS];
  int            log_src [$];
  int            bubble;
  int            rdy_mode;
  int            pat_idx;
  bit            rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input int s, input int len);
    logic [BW-1:0] b;
    for (int i = 0; i < len; i++) begin
      b[DW-1:0]     = $urandom;
      b[DW+KW-1:DW] = (i == len - 1) ? KW'($urandom_range(1, (1 << KW) - 1)) : '1;
      b[BW-1]       = (i == len - 1);
      q[s].push_back(b);
    end
  endtask

  function automatic logic [NS*CW-1:0] exp_cnt();
    logic [NS*CW-1:0] e;
    e = '0;
    for (int i = 0; i < NS; i++) e[i*CW +: CW] = CW'(mc[i]);
    return e;
  endfunction

  task automatic drive();
    logic [BW-1:0] b;
    for (int i = 0; i < NS; i++) begin
      if (!pres[i] && q[i].size() > 0 && int'($urandom_range(99)) >= bubble) pres[i] = 1'b1;
      b = (pres[i] && q[i].size() > 0) ? q[i][0] : '0;
      s_tvalid[i]          = pres[i];
      s_tdata[i*DW +: DW]  = b[DW-1:0];
      s_tkeep[i*KW +: KW]  = b[DW+KW-1:DW];
      s_tlast[i]           = b[BW-1];
    end
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ($urandom_range(99) < 70);
      default: m_tready = rdy_pat[pat_idx % 4];
    endcase
    pat_idx++;
  endtask

  task automatic check_outputs();
    chk("busy", 64'(busy), 64'(mb));
    chk("pkt_cnt", 64'(pkt_cnt), 64'(exp_cnt()));
    if (!mb) begin
      chk("idle_m_tvalid", 64'(m_tvalid), 64'(0));
      chk("idle_s_tready", 64'(s_tready), 64'(0));
    end else begin
      chk("grant_id", 64'(grant_id), 64'(mg));
      chk("m_tvalid", 64'(m_tvalid), 64'(pres[mg]));
      chk("s_tready", 64'(s_tready), m_tready ? (64'(1) << mg) : 64'(0));
      if (pres[mg]) chk("beat", 64'({m_tlast, m_tkeep, m_tdata}), 64'(q[mg][0]));
    end
  endtask

  // One clock: drive after the edge, check mid-cycle, advance the model by the handshake rules.
  task automatic cycle();
    logic [BW-1:0] b;
    int            w;
    drive();
    #4;
    check_outputs();
    if (mb) begin
      if (pres[mg] && m_tready) begin
        b = q[mg].pop_front();
        pres[mg] = 1'b0;
        if (b[BW-1]) begin
          mc[mg] = (mc[mg] + 1) % (1 << CW);
          ml     = mg;
          mb     = 1'b0;
          log_src.push_back(mg);
        end
      end
    end else if (link_up) begin
      w = -1;
      for (int k = 1; k <= NS; k++)
        if (w < 0 && pres[(ml + k) % NS]) w = (ml + k) % NS;
      if (w >= 0) begin
        mb = 1'b1;
        mg = w;
      end
    end
    @(posedge TX_clk);
    #1;
  endtask

  task automatic do_reset();
    TX_rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_grant_id", 64'(grant_id), 64'(0));
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_m_tlast", 64'(m_tlast), 64'(0));
    chk("rst_m_tdata", 64'(m_tdata), 64'(0));
    chk("rst_m_tkeep", 64'(m_tkeep), 64'(0));
    chk("rst_s_tready", 64'(s_tready), 64'(0));
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
    for (int i = 0; i < NS; i++) begin
      q[i].delete();
      pres[i] = 1'b0;
      mc[i]   = 0;
    end
    mb = 1'b0;
    mg = 0;
    ml = NS - 1;
    @(posedge TX_clk);
    #1;
    TX_rst_n = 1'b1;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    bit pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < max_cycles) begin
      cycle();
      n++;
      pending = mb;
      for (int i = 0; i < NS; i++) if (q[i].size() > 0) pending = 1'b1;
    end
    chk("drain_timeout", 64'(pending), 64'(0));
  endtask

  initial begin
    TX_rst_n = 1'b1;
    link_up  = 1'b1;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
    bubble   = 0;
    rdy_mode = 0;
    pat_idx  = 0;
    #1;
    do_reset();

    // Single 3-beat packet from src0: grant one cycle after valid, count updates on tlast.
    push_pkt(0, 3);
    cycle();
    chk("t1_busy_after_arb", 64'(busy), 64'(1));
    drain(20);
    cycle();
    chk("t1_pkt_cnt0", 64'(pkt_cnt[CW-1:0]), 64'(1));
    chk("t1_busy_end", 64'(busy), 64'(0));
    chk("t1_log", 64'(log_src.size() == 1 && log_src[0] == 0), 64'(1));

    // Both sources continuously offering 2-beat packets alternate from reset.
    do_reset();
    log_src.delete();
    for (int i = 0; i < 4; i++) begin
      push_pkt(0, 2);
      push_pkt(1, 2);
    end
    drain(60);
    chk("t2_count", 64'(log_src.size()), 64'(8));
    for (int i = 0; i < log_src.size(); i++) chk("t2_order", 64'(log_src[i]), 64'(i % 2));

    // src1 holds the grant under a 1,0,0,1 ready pattern while src0 waits.
    log_src.delete();
    push_pkt(1, 4);
    cycle();
    push_pkt(0, 2);
    rdy_mode = 2;
    pat_idx  = 0;
    drain(40);
    rdy_mode = 0;
    chk("t3_first", 64'(log_src[0]), 64'(1));

    // Link down blocks arbitration; raising it grants on the next cycle.
    link_up = 1'b0;
    push_pkt(0, 2);
    repeat (10) cycle();
    chk("t4_no_grant", 64'(busy), 64'(0));
    link_up = 1'b1;
    cycle();
    chk("t4_grant", 64'(busy), 64'(1));
    drain(20);

    // Link drops mid-packet: packet completes, nothing new is granted.
    push_pkt(0, 5);
    cycle();
    push_pkt(1, 2);
    cycle();
    cycle();
    link_up = 1'b0;
    begin
      int n;
      n = 0;
      while (q[0].size() > 0 && n < 20) begin
        cycle();
        n++;
      end
      chk("t4b_timeout", 64'(q[0].size()), 64'(0));
    end
    repeat (5) cycle();
    chk("t4b_no_grant", 64'(busy), 64'(0));
    chk("t4b_src1_waiting", 64'(q[1].size()), 64'(2));
    link_up = 1'b1;
    drain(20);

    // Reset in the middle of a src1 packet, then src0 wins the first arbitration.
    push_pkt(1, 4);
    cycle();
    cycle();
    drive();
    #1;
    do_reset();
    log_src.delete();
    push_pkt(0, 1);
    push_pkt(1, 1);
    drain(20);
    chk("t5_first_src0", 64'(log_src[0]), 64'(0));

    // Counter wrap with a narrow counter.
    do_reset();
    for (int i = 0; i < (1 << CW) - 1; i++) push_pkt(0, 1);
    drain(100);
    chk("t6_cnt_max", 64'(pkt_cnt[CW-1:0]), 64'((1 << CW) - 1));
    push_pkt(0, 1);
    drain(10);
    chk("t6_cnt_wrap", 64'(pkt_cnt[CW-1:0]), 64'(0));

    // Randomized traffic, bubbles, backpressure and link flaps.
    bubble   = 30;
    rdy_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      link_up = ($urandom_range(99) >= 5);
      if ($urandom_range(99) < 15) begin
        int s;
        s = $urandom_range(NS - 1);
        if (q[s].size() < 8) push_pkt(s, $urandom_range(1, 4));
      end
      cycle();
    end
    link_up = 1'b1;
    drain(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/c2h_stream_arbiter.md
Name: c2h_stream_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single PCIe C2H AXI-Stream port among NUM_SRC requesters, e.g. KVS response path plus a stats/debug channel.
- Sits between the requesters and the DMA engine's S_AXIS_C2H port, in the PCIe user clock domain (250 MHz).
- Holds a grant from the first beat of a packet through its tlast handshake, so packets never interleave.
- Gates new grants on PCIe link-up.

Parameters:
- NUM_SRC, 2, number of requesters (2..4).
- DATA_WIDTH, 256, AXIS tdata width; tkeep is DATA_WIDTH/8.
- CNT_WIDTH, 32, width of each per-source packet counter.

Ports:
- TX_clk  in  1  PCIe user clock; the only clock, all logic on its rising edge.
- TX_rst_n  in  1  asynchronous active-low reset.
- link_up  in  1  PCIe link-up, synchronous to TX_clk; 0 blocks new grants.
- s_tvalid  in  NUM_SRC  per-source valid.
- s_tready  out  NUM_SRC  per-source ready.
- s_tdata  in  NUM_SRC*DATA_WIDTH  source i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- s_tkeep  in  NUM_SRC*DATA_WIDTH/8  per-source keep, packed the same way.
- s_tlast  in  NUM_SRC  per-source last.
- m_tvalid  out  1  to S_AXIS_C2H_tvalid.
- m_tready  in  1  from S_AXIS_C2H_tready.
- m_tdata  out  DATA_WIDTH  to S_AXIS_C2H_tdata.
- m_tkeep  out  DATA_WIDTH/8  to S_AXIS_C2H_tkeep.
- m_tlast  out  1  to S_AXIS_C2H_tlast.
- busy  out  1  1 while a grant is held.
- grant_id  out  2  index of the granted source; valid when busy=1.
- pkt_cnt  out  NUM_SRC*CNT_WIDTH  completed-packet count per source.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, busy=0, grant_id=0.
  - last_grant=NUM_SRC-1, so source 0 has first priority.
  - All pkt_cnt=0, s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, m_tkeep=0.
- State IDLE:
  - m_tvalid=0 and all s_tready=0.
  - If link_up=1 and any s_tvalid=1, select the first requesting source scanning from last_grant+1 upward, modulo NUM_SRC.
  - Register that index into grant_id, go to BUSY, busy=1 at the next edge.
  - Arbitration latency: 1 cycle from s_tvalid to the grant being visible.
- State BUSY, combinational mux from grant_id:
  - m_tvalid/m_tdata/m_tkeep/m_tlast follow the granted source's s_tvalid/s_tdata/s_tkeep/s_tlast.
  - s_tready[grant_id]=m_tready; every other s_tready=0.
  - m_tdata/m_tkeep are don't-care when m_tvalid=0, but are driven from the granted source, not X.
- End of packet: on m_tvalid & m_tready & m_tlast in BUSY:
  - pkt_cnt[grant_id] increments by 1, wrapping modulo 2^CNT_WIDTH.
  - last_grant<=grant_id, state returns to IDLE, busy=0 next cycle.
  - This costs one mandatory idle cycle between packets, i.e. a 1-cycle bubble.
- Single-beat packet (tvalid & tlast on the first beat): handled identically; grant is held for exactly one BUSY cycle if m_tready=1.
- Backpressure: m_tready=0 stalls the granted source in place; the grant never times out.
- Source bubbles (s_tvalid=0) mid-packet: the grant is held and m_tvalid=0.
- link_up falls mid-packet: the current packet runs to tlast; no new grant is issued until link_up=1.
- Simultaneous requests: only round-robin order decides; a source that has just completed a packet has lowest priority in the next arbitration.
- A source asserting tvalid while not granted sees s_tready=0 and must hold its data (AXIS rule).
- Reset asserted mid-packet: the packet is abandoned immediately, all outputs go to reset values, counters clear.
- grant_id values >= NUM_SRC never occur.

Test Plan:
- Reset then only src0 sends a 3-beat packet, m_tready=1 -> m_tvalid rises 1 cycle after s_tvalid; 3 beats out with tlast on beat 3; pkt_cnt[0]=1, busy returns to 0.
- src0 and src1 both continuously send 2-beat packets, NUM_SRC=2 -> output order src0,src1,src0,src1; never two consecutive from one source; 1 idle cycle between packets; no interleaved beats.
- Granted src1 packet of 4 beats with m_tready toggling 1,0,0,1,... -> each beat appears exactly once in order; s_tready[0] stays 0 throughout although s_tvalid[0]=1.
- link_up=0 with src0 valid -> no grant for 10 cycles; link_up=1 -> grant on the next cycle. Separately, link_up drops at beat 2 of 5 -> all 5 beats delivered, then no new grant.
- TX_rst_n pulsed low at beat 2 of a src1 packet -> m_tvalid and all s_tready go 0 immediately, pkt_cnt all 0; after release, src0 wins the first arbitration.
- Preload pkt_cnt[0]=0xFFFFFFFF via 2^32-equivalent forcing -> next src0 completion gives 0x00000000.
